// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encoding, FSM states and latency limit for the LSU memory port.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_ILL = 2'd3} size_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;
  localparam int unsigned LAT_MAX = 15;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane mask, store replication and load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    // Shifting a 4-bit mask drops lanes past byte 3 for misaligned halves.
    wmask = size == SZ_B ? 4'b0001 << addr_lo : size == SZ_H ? 4'b0011 << addr_lo :
            size == SZ_W ? 4'b1111 : 4'b0000;
    wdata_rep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == SZ_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
                size == SZ_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port with LAT wait cycles before each access.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned LAT       = 1,
  parameter logic [31:0] IDLE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);
  localparam logic [3:0] LAT_INIT = LAT > 0 ? 4'(LAT - 1) : 4'd0;
  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d, uns_q, uns_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        fault, access, ld_access, st_access;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, lane_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
  assign fault = req_size == SZ_ILL || (req_size == SZ_H && req_addr[0]) ||
                 (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
  assign fault = req_size == SZ_ILL;
`endif
  lsu_lane_align u_align (
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .rdata    (mem_rdata),
    .wmask    (lane_mask),
    .wdata_rep(lane_wdata),
    .rdata_ext(lane_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wen_d   = req_wen;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = size_e'(req_size);
        uns_d   = req_unsigned;
        rdata_d = '0;
        err_d   = fault;
        cnt_d   = LAT_INIT;
        state_d = fault ? S_RESP : LAT > 0 ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
      end
      S_ACCESS: begin
        rdata_d = wen_q ? 32'd0 : lane_rdata;
        state_d = S_RESP;
      end
      S_RESP: state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign access     = state_q == S_ACCESS;
  assign ld_access  = access && !wen_q;
  assign st_access  = access && wen_q;
  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_raddr  = ld_access ? {addr_q[31:2], 2'b00} : IDLE_ADDR;
  assign mem_waddr  = access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wen    = st_access && !rst;
  assign mem_wmask  = st_access ? lane_mask : 4'd0;
  assign mem_wdata  = st_access ? lane_wdata : 32'd0;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port at LAT=1 (main) and LAT=0 (backpressure).
module tb_lsu_mem_port;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_valid = 1'b0, resp_ready = 1'b0, req_valid0 = 1'b0, resp_ready0 = 1'b0;
  logic        req_ready, resp_valid, resp_err, mem_wen;
  logic [31:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        req_ready0, resp_valid0, resp_err0, mem_wen0;
  logic [31:0] resp_rdata0, mem_raddr0, mem_rdata0, mem_waddr0, mem_wdata0;
  logic [3:0]  mem_wmask0;
  logic [31:0] mem_word = 32'h80FF_1234;
  int          vectors = 0, miscompares = 0, wen_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [3:0]  last_wmask = '0;

  always #5 clk = ~clk;
  assign mem_rdata  = mem_raddr[31:12] == 20'h80000 ? mem_word : 32'd0;
  assign mem_rdata0 = mem_raddr0[31:12] == 20'h80000 ? mem_word : 32'd0;

  lsu_mem_port #(.LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );
  lsu_mem_port #(.LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_raddr(mem_raddr0), .mem_rdata(mem_rdata0), .mem_wen(mem_wen0), .mem_waddr(mem_waddr0),
    .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0)
  );

  always @(negedge clk) if (mem_wen) begin
    wen_cnt++;
    last_waddr = mem_waddr;
    last_wmask = mem_wmask;
    last_wdata = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit d0, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u);
    chk("accept_ready", d0 ? req_ready0 : req_ready, 1);
    req_wen = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    if (d0) req_valid0 = 1'b1; else req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_valid0 = 1'b0;
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_vdone"}, resp_valid, 0);
    chk({tag, "_rdy"}, req_ready, 1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] exp);
    issue(0, 1'b0, a, 32'd0, sz, u);
    chk({tag, "_v0"}, resp_valid, 0);
    tick();
    chk({tag, "_raddr"}, mem_raddr, {a[31:2], 2'b00});
    chk({tag, "_v1"}, resp_valid, 0);
    tick();
    chk({tag, "_v2"}, resp_valid, 1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_ridle"}, mem_raddr, 32'h8000_0000);
    consume(tag);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [3:0] m, input logic [31:0] d);
    wen_cnt = 0;
    issue(0, 1'b1, a, wd, sz, 1'b0);
    tick();
    tick();
    chk({tag, "_v"}, resp_valid, 1);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
    chk({tag, "_wcnt"}, wen_cnt, 1);
    chk({tag, "_waddr"}, last_waddr, {a[31:2], 2'b00});
    chk({tag, "_wmask"}, last_wmask, m);
    chk({tag, "_wdata"}, last_wdata, d);
    chk({tag, "_mask_idle"}, mem_wmask, 0);
    chk({tag, "_wdata_idle"}, mem_wdata, 0);
    consume(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("rst_valid", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_raddr", mem_raddr, 32'h8000_0000);
    chk("rst_waddr", mem_waddr, 0);
    rst = 1'b0;
    tick();

    do_load("lb3", 32'h8000_0003, 2'd0, 1'b0, 32'hFFFF_FF80);
    do_load("lbu3", 32'h8000_0003, 2'd0, 1'b1, 32'h0000_0080);
    do_load("lb1", 32'h8000_0001, 2'd0, 1'b0, 32'h0000_0012);
    do_load("lh2", 32'h8000_0002, 2'd1, 1'b0, 32'hFFFF_80FF);
    do_load("lhu0", 32'h8000_0000, 2'd1, 1'b1, 32'h0000_1234);
    do_load("lw", 32'h8000_0100, 2'd2, 1'b0, 32'h80FF_1234);

    do_store("sh2", 32'h8000_0002, 32'h0000_ABCD, 2'd1, 4'b1100, 32'hABCD_ABCD);
    do_store("sb1", 32'h8000_0001, 32'h1234_5678, 2'd0, 4'b0010, 32'h7878_7878);
    do_store("sw", 32'h8000_0104, 32'hDEAD_BEEF, 2'd2, 4'b1111, 32'hDEAD_BEEF);

    issue(0, 1'b0, 32'h8000_0010, 32'd0, 2'd3, 1'b0);
    chk("ill_ld_v", resp_valid, 1);
    chk("ill_ld_err", resp_err, 1);
    chk("ill_ld_rdata", resp_rdata, 0);
    chk("ill_ld_raddr", mem_raddr, 32'h8000_0000);
    tick();
    chk("ill_ld_raddr2", mem_raddr, 32'h8000_0000);
    consume("ill_ld");
    wen_cnt = 0;
    issue(0, 1'b1, 32'h8000_0010, 32'h5555_5555, 2'd3, 1'b0);
    chk("ill_st_err", resp_err, 1);
    tick();
    tick();
    chk("ill_st_wcnt", wen_cnt, 0);
    consume("ill_st");

    wen_cnt = 0;
    issue(0, 1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_v", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_rdata", resp_rdata, 0);
    tick();
    tick();
    chk("mis_wcnt", wen_cnt, 0);
`else
    chk("mis_v0", resp_valid, 0);
    tick();
    tick();
    chk("mis_v", resp_valid, 1);
    chk("mis_err", resp_err, 0);
    chk("mis_wcnt", wen_cnt, 0);
`endif
    consume("mis");

    wen_cnt = 0;
    issue(0, 1'b1, 32'h8000_0000, 32'h1111_1111, 2'd2, 1'b0);
    rst = 1'b1;
    chk("abort_wen_rst", mem_wen, 0);
    tick();
    rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", resp_valid, 0);
    tick();
    tick();
    chk("abort_wcnt", wen_cnt, 0);
    chk("abort_valid2", resp_valid, 0);

    mem_word = 32'h80FF_1234;
    issue(1, 1'b0, 32'h8000_0000, 32'd0, 2'd1, 1'b1);
    chk("l0_v0", resp_valid0, 0);
    tick();
    chk("l0_v1", resp_valid0, 1);
    chk("l0_rdata", resp_rdata0, 32'h0000_1234);
    mem_word = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("l0_hold_v", resp_valid0, 1);
      chk("l0_hold_rdata", resp_rdata0, 32'h0000_1234);
      chk("l0_hold_rdy", req_ready0, 0);
      tick();
    end
    resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;
    chk("l0_done_v", resp_valid0, 0);
    chk("l0_done_rdy", req_ready0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
